channel_select_controller: RTL and testbench

- Produces the 3-bit `curr_channel` code consumed by the RGB LED indicator and the display path.
- Debounces two user push buttons, "next" and "prev", and steps the active channel up or down modulo NUM_CHANNELS.
- Emits a one-cycle `channel_changed` strobe so downstream blocks can flush per-channel state.

---
 rtl/channel_select_controller.sv | 194 +++++++++++++++++++
 tb/tb_channel_select_controller.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_select_controller.sv
// ============================================================================
// channel_select_controller
// ----------------------------------------------------------------------------
// Purpose:
//   Debounces the "next" and "prev" push buttons and steps the active channel
//   up or down modulo NUM_CHANNELS. The registered channel code drives the RGB
//   LED indicator and the display path. A one-cycle strobe tells downstream
//   blocks to flush their per-channel state whenever the code changes.
//
// Ports:
//   clk              system clock
//   reset            asynchronous, active-high reset (released synchronously)
//   btn_next         raw asynchronous push button, active-high, steps up
//   btn_prev         raw asynchronous push button, active-high, steps down
//   curr_channel     current channel code, registered, 0..NUM_CHANNELS-1
//   channel_changed  one-cycle pulse on the cycle curr_channel takes a new value
//   btn_active       high while either debouncer is in PRESSED or RELEASE_WAIT
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized cycles needed to accept a press or a
//                    release (minimum 2)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   NUM_CHANNELS     number of valid channel codes, 2..8
//   AUTO_CYCLES      auto-advance period, used only with the macro below
//
// Optional feature (macro CHANNEL_AUTO_CYCLE_EN):
//   When defined, a 32-bit idle timer runs while both debouncers are IDLE and
//   performs a "next" step every AUTO_CYCLES cycles. Any debouncer activity
//   clears the timer. When undefined, only accepted presses change the channel.
// ============================================================================
module channel_select_controller #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int NUM_CHANNELS    = 3,
   parameter int AUTO_CYCLES     = 500000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_next,
   input  logic       btn_prev,
   output logic [2:0] curr_channel,
   output logic       channel_changed,
   output logic       btn_active
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } deb_state_t;

   // The sample that moves the FSM out of IDLE (or PRESSED) is itself the
   // first stable sample, so the counter holds "stable samples seen minus
   // one". The press/release is accepted on the edge that sees the
   // DEBOUNCE_CYCLES-th consecutive stable sample.
   localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [2:0]       CHAN_LAST  = 3'(NUM_CHANNELS - 1);

   // Elaboration-time guard against illegal parameter combinations.
   if ((NUM_CHANNELS < 2) || (NUM_CHANNELS > 8) || (DEBOUNCE_CYCLES < 2) ||
       ((64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) || (AUTO_CYCLES < 1)) begin : g_param_check
      $error("channel_select_controller: illegal parameter combination");
   end

   // Index 0 is the "next" button, index 1 is the "prev" button.
   logic [1:0]       btn_raw;
   logic [1:0]       sync_ff1;
   logic [1:0]       sync;
   deb_state_t       deb_state [2];
   logic [CNT_W-1:0] deb_count [2];
   logic [1:0]       accept;
   logic             step_next;
   logic             step_prev;
   logic             auto_step;

   assign btn_raw = {btn_prev, btn_next};

   // Two-flop synchronizers plus the per-button debounce FSMs. Only the
   // second synchronizer flop is allowed to feed the FSMs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_ff1 <= '0;
         sync     <= '0;
         for (int i = 0; i < 2; i++) begin
            deb_state[i] <= IDLE;
            deb_count[i] <= '0;
         end
      end else begin
         sync_ff1 <= btn_raw;
         sync     <= sync_ff1;
         for (int i = 0; i < 2; i++) begin
            case (deb_state[i])
               IDLE: begin
                  if (sync[i]) begin
                     deb_state[i] <= PRESS_WAIT;
                     deb_count[i] <= '0;
                  end
               end
               PRESS_WAIT: begin
                  if (!sync[i]) begin
                     deb_state[i] <= IDLE;
                     deb_count[i] <= '0;
                  end else if (deb_count[i] == COUNT_LAST) begin
                     deb_state[i] <= PRESSED;
                     deb_count[i] <= '0;
                  end else begin
                     deb_count[i] <= deb_count[i] + CNT_W'(1);
                  end
               end
               PRESSED: begin
                  if (!sync[i]) begin
                     deb_state[i] <= RELEASE_WAIT;
                     deb_count[i] <= '0;
                  end
               end
               RELEASE_WAIT: begin
                  if (sync[i]) begin
                     deb_state[i] <= PRESSED;
                     deb_count[i] <= '0;
                  end else if (deb_count[i] == COUNT_LAST) begin
                     deb_state[i] <= IDLE;
                     deb_count[i] <= '0;
                  end else begin
                     deb_count[i] <= deb_count[i] + CNT_W'(1);
                  end
               end
               default: begin
                  deb_state[i] <= IDLE;
                  deb_count[i] <= '0;
               end
            endcase
         end
      end
   end

   // Accept pulse: high for the one cycle in which the FSM is about to move
   // from PRESS_WAIT to PRESSED, so the channel updates on that same edge.
   always_comb begin
      accept = '0;
      for (int i = 0; i < 2; i++) begin
         accept[i] = (deb_state[i] == PRESS_WAIT) && sync[i] &&
                     (deb_count[i] == COUNT_LAST);
      end
   end

   // Simultaneous next and prev cancel each other out.
   assign step_next = accept[0] & ~accept[1];
   assign step_prev = accept[1] & ~accept[0];

   assign btn_active = (deb_state[0] == PRESSED) || (deb_state[0] == RELEASE_WAIT) ||
                       (deb_state[1] == PRESSED) || (deb_state[1] == RELEASE_WAIT);

`ifdef CHANNEL_AUTO_CYCLE_EN
   logic [31:0] idle_timer;
   logic        both_idle;

   assign both_idle = (deb_state[0] == IDLE) && (deb_state[1] == IDLE);
   assign auto_step = both_idle && (idle_timer == 32'(AUTO_CYCLES - 1));

   // Idle timer: runs only while neither button is being handled, so any
   // press activity (including an accepted press) restarts the period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_timer <= '0;
      end else if (!both_idle || auto_step) begin
         idle_timer <= '0;
      end else begin
         idle_timer <= idle_timer + 32'd1;
      end
   end
`else
   assign auto_step = 1'b0;
`endif

   // Channel register and change strobe. Both are registered so the strobe
   // is high exactly during the first cycle of the new channel value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         curr_channel    <= '0;
         channel_changed <= 1'b0;
      end else begin
         channel_changed <= 1'b0;
         if (step_next || auto_step) begin
            curr_channel    <= (curr_channel == CHAN_LAST) ? 3'd0 : curr_channel + 3'd1;
            channel_changed <= 1'b1;
         end else if (step_prev) begin
            curr_channel    <= (curr_channel == 3'd0) ? CHAN_LAST : curr_channel - 3'd1;
            channel_changed <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_channel_select_controller.sv
// ============================================================================
// tb_channel_select_controller
// ----------------------------------------------------------------------------
// Self-checking bench for channel_select_controller with a short debounce
// window. A behavioural model tracks run lengths of synchronized button levels
// and a pressed flag per button, and computes the channel with modulo
// arithmetic. Inputs change on the falling edge; outputs are sampled there.
// ============================================================================
module tb_channel_select_controller;

   localparam int DEB  = 4;
   localparam int NCH  = 3;
   localparam int AUTO = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_next = 1'b0;
   logic       btn_prev = 1'b0;
   logic [2:0] curr_channel;
   logic       channel_changed;
   logic       btn_active;

   int total = 0;
   int passed = 0;
   int pulse_count = 0;

   always #5 clk = ~clk;

   channel_select_controller #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W(4),
      .NUM_CHANNELS(NCH),
      .AUTO_CYCLES(AUTO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_next(btn_next),
      .btn_prev(btn_prev),
      .curr_channel(curr_channel),
      .channel_changed(channel_changed),
      .btn_active(btn_active)
   );

   // Reference model state: synchronizer delay line, pressed flags, current
   // run length of the level being debounced, channel, strobe and idle timer.
   typedef struct packed {
      logic [1:0] s1;
      logic [1:0] s2;
      logic [1:0] pressed;
      int         run0;
      int         run1;
      int         chan;
      logic       changed;
      int         timer;
   } model_t;

   model_t mdl;

   function automatic model_t model_next(input model_t m, input logic [1:0] raw);
      model_t     n;
      int         run [2];
      logic [1:0] acc;
      logic       auto_step;
      n         = m;
      n.changed = 1'b0;
      acc       = '0;
      auto_step = 1'b0;
      run[0]    = m.run0;
      run[1]    = m.run1;
      for (int i = 0; i < 2; i++) begin
         if (!m.pressed[i]) begin
            if (m.s2[i]) begin
               run[i]++;
               if (run[i] == DEB) begin
                  acc[i]       = 1'b1;
                  n.pressed[i] = 1'b1;
                  run[i]       = 0;
               end
            end else begin
               run[i] = 0;
            end
         end else begin
            if (!m.s2[i]) begin
               run[i]++;
               if (run[i] == DEB) begin
                  n.pressed[i] = 1'b0;
                  run[i]       = 0;
               end
            end else begin
               run[i] = 0;
            end
         end
      end
`ifdef CHANNEL_AUTO_CYCLE_EN
      if ((m.pressed == 2'b00) && (m.run0 == 0) && (m.run1 == 0)) begin
         if (m.timer == AUTO - 1) begin
            auto_step = 1'b1;
            n.timer   = 0;
         end else begin
            n.timer = m.timer + 1;
         end
      end else begin
         n.timer = 0;
      end
`endif
      if ((acc == 2'b01) || auto_step) begin
         n.chan    = (m.chan + 1) % NCH;
         n.changed = 1'b1;
      end else if (acc == 2'b10) begin
         n.chan    = (m.chan + NCH - 1) % NCH;
         n.changed = 1'b1;
      end
      n.run0 = run[0];
      n.run1 = run[1];
      n.s2   = m.s1;
      n.s1   = raw;
      return n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) mdl <= '0;
      else       mdl <= model_next(mdl, {btn_prev, btn_next});
   end

   // Advance n falling edges, counting change strobes seen on the way.
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         if (channel_changed) pulse_count++;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset    = 1'b1;
      btn_next = 1'b0;
      btn_prev = 1'b0;
      tick(3);
      reset       = 1'b0;
      pulse_count = 0;
   endtask

   task automatic press(input bit use_prev, input int hold, input int rel);
      if (use_prev) btn_prev = 1'b1;
      else          btn_next = 1'b1;
      tick(hold);
      btn_prev = 1'b0;
      btn_next = 1'b0;
      tick(rel);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset    = 1'b1;
      btn_next = 1'b1;
      tick(3);
      total++;
      if (curr_channel !== 3'd0) $display("[TB] FAIL reset_channel: got %0d expected 0", curr_channel);
      else passed++;
      total++;
      if (channel_changed !== 1'b0) $display("[TB] FAIL reset_changed: got %0b expected 0", channel_changed);
      else passed++;
      total++;
      if (btn_active !== 1'b0) $display("[TB] FAIL reset_active: got %0b expected 0", btn_active);
      else passed++;
      reset    = 1'b0;
      btn_next = 1'b0;
      tick(1);
      total++;
      if (curr_channel !== 3'd0) $display("[TB] FAIL reset_release_channel: got %0d expected 0", curr_channel);
      else passed++;
   endtask

   task automatic test_latency();
      int change_edge;
      apply_reset();
      btn_next    = 1'b1;
      change_edge = 0;
      for (int e = 1; e <= 20; e++) begin
         tick(1);
         if (channel_changed && change_edge == 0) change_edge = e;
         total++;
         if (curr_channel !== 3'(mdl.chan) || channel_changed !== mdl.changed || btn_active !== (|mdl.pressed))
            $display("[TB] FAIL latency_model edge %0d: got ch=%0d chg=%0b act=%0b expected ch=%0d chg=%0b act=%0b",
                     e, curr_channel, channel_changed, btn_active, mdl.chan, mdl.changed, |mdl.pressed);
         else passed++;
      end
      total++;
      if (change_edge !== 6) $display("[TB] FAIL latency_edge: got %0d expected 6", change_edge);
      else passed++;
      total++;
      if (pulse_count !== 1) $display("[TB] FAIL latency_pulses: got %0d expected 1", pulse_count);
      else passed++;
      total++;
      if (curr_channel !== 3'd1) $display("[TB] FAIL latency_channel: got %0d expected 1", curr_channel);
      else passed++;
      btn_next = 1'b0;
      tick(10);
   endtask

   task automatic test_sequence();
      int exp_seq [3] = '{1, 2, 0};
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         press(1'b0, 8, 8);
         total++;
         if (curr_channel !== 3'(exp_seq[k]))
            $display("[TB] FAIL sequence_next%0d: got %0d expected %0d", k, curr_channel, exp_seq[k]);
         else passed++;
      end
      press(1'b1, 8, 8);
      total++;
      if (curr_channel !== 3'd2) $display("[TB] FAIL prev_wrap: got %0d expected 2", curr_channel);
      else passed++;
   endtask

   task automatic test_glitch();
      apply_reset();
      btn_next = 1'b1; tick(3);
      btn_next = 1'b0; tick(1);
      btn_next = 1'b1; tick(3);
      btn_next = 1'b0; tick(10);
      total++;
      if (pulse_count !== 0 || curr_channel !== 3'd0)
         $display("[TB] FAIL press_glitch: got pulses=%0d ch=%0d expected pulses=0 ch=0", pulse_count, curr_channel);
      else passed++;
      pulse_count = 0;
      btn_next = 1'b1; tick(8);
      btn_next = 1'b0; tick(2);
      btn_next = 1'b1; tick(1);
      btn_next = 1'b0; tick(10);
      total++;
      if (pulse_count !== 1 || curr_channel !== 3'd1)
         $display("[TB] FAIL release_bounce: got pulses=%0d ch=%0d expected pulses=1 ch=1", pulse_count, curr_channel);
      else passed++;
      total++;
      if (btn_active !== 1'b0) $display("[TB] FAIL release_idle_active: got %0b expected 0", btn_active);
      else passed++;
   endtask

   task automatic test_simultaneous();
      apply_reset();
      btn_next = 1'b1;
      btn_prev = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick(1);
         if (e == 5) begin
            total++;
            if (btn_active !== 1'b0) $display("[TB] FAIL both_active_edge5: got %0b expected 0", btn_active);
            else passed++;
         end
         if (e == 6) begin
            total++;
            if (btn_active !== 1'b1) $display("[TB] FAIL both_active_edge6: got %0b expected 1", btn_active);
            else passed++;
         end
      end
      total++;
      if (pulse_count !== 0 || curr_channel !== 3'd0)
         $display("[TB] FAIL both_cancel: got pulses=%0d ch=%0d expected pulses=0 ch=0", pulse_count, curr_channel);
      else passed++;
      btn_next = 1'b0;
      btn_prev = 1'b0;
      tick(10);
   endtask

   task automatic test_reset_mid();
      int acc_edge;
      apply_reset();
      press(1'b0, 8, 8);
      total++;
      if (curr_channel !== 3'd1) $display("[TB] FAIL midreset_setup: got %0d expected 1", curr_channel);
      else passed++;
      btn_next = 1'b1;
      tick(5);
      reset = 1'b1;
      #1;
      total++;
      if (curr_channel !== 3'd0 || channel_changed !== 1'b0)
         $display("[TB] FAIL midreset_abort: got ch=%0d chg=%0b expected ch=0 chg=0", curr_channel, channel_changed);
      else passed++;
      tick(2);
      reset    = 1'b0;
      acc_edge = 0;
      for (int e = 1; e <= 12; e++) begin
         tick(1);
         if (channel_changed && acc_edge == 0) acc_edge = e;
      end
      total++;
      if (acc_edge !== 6 || curr_channel !== 3'd1)
         $display("[TB] FAIL midreset_held: got edge=%0d ch=%0d expected edge=6 ch=1", acc_edge, curr_channel);
      else passed++;
      btn_next = 1'b0;
      tick(10);
   endtask

   task automatic test_random();
      int cyc = 0;
      int len;
      apply_reset();
      while (cyc < 800) begin
         btn_next = 1'($urandom_range(0, 1));
         btn_prev = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 9);
         for (int j = 0; j < len; j++) begin
            @(negedge clk);
            cyc++;
            total++;
            if (curr_channel !== 3'(mdl.chan) || channel_changed !== mdl.changed || btn_active !== (|mdl.pressed))
               $display("[TB] FAIL random_model cycle %0d: got ch=%0d chg=%0b act=%0b expected ch=%0d chg=%0b act=%0b",
                        cyc, curr_channel, channel_changed, btn_active, mdl.chan, mdl.changed, |mdl.pressed);
            else passed++;
         end
      end
      btn_next = 1'b0;
      btn_prev = 1'b0;
      tick(10);
   endtask

`ifdef CHANNEL_AUTO_CYCLE_EN
   task automatic test_auto();
      apply_reset();
      for (int e = 1; e <= 20; e++) begin
         tick(1);
         if (e == 9) begin
            total++;
            if (curr_channel !== 3'd0) $display("[TB] FAIL auto_edge9: got %0d expected 0", curr_channel);
            else passed++;
         end
         if (e == 10) begin
            total++;
            if (curr_channel !== 3'd1 || channel_changed !== 1'b1)
               $display("[TB] FAIL auto_edge10: got ch=%0d chg=%0b expected ch=1 chg=1", curr_channel, channel_changed);
            else passed++;
         end
         if (e == 20) begin
            total++;
            if (curr_channel !== 3'd2) $display("[TB] FAIL auto_edge20: got %0d expected 2", curr_channel);
            else passed++;
         end
      end
      for (int c = 1; c <= 60; c++) begin
         if (c == 5)  btn_next = 1'b1;
         if (c == 13) btn_next = 1'b0;
         @(negedge clk);
         total++;
         if (curr_channel !== 3'(mdl.chan) || channel_changed !== mdl.changed)
            $display("[TB] FAIL auto_restart cycle %0d: got ch=%0d chg=%0b expected ch=%0d chg=%0b",
                     c, curr_channel, channel_changed, mdl.chan, mdl.changed);
         else passed++;
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef CHANNEL_AUTO_CYCLE_EN
      test_auto();
`else
      test_latency();
      test_sequence();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
